// File: rtl/event_encoder_nbit_pkg.sv
// Shared helpers for the event encoder: width helper, one-hot expansion and
// the reset value of the round-robin pointer.
package encoder_pkg;

  localparam int MAX_W = 256;

  // All ones so that the first round-robin search starts at index 0.
  localparam logic [31:0] RR_LAST_RESET = 32'hFFFF_FFFF;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  function automatic logic [MAX_W-1:0] onehot(input int unsigned index);
    logic [MAX_W-1:0] one;
    one = {{(MAX_W-1){1'b0}}, 1'b1};
    return one << index;
  endfunction

endpackage

// File: rtl/event_encoder_nbit_if.sv
// Request/handshake bundle between the event encoder and its producer/consumer.
interface event_encoder_nbit_if #(
  parameter int N = 3
);
  logic                enable;
  logic [(1<<N)-1:0]   req;
  logic                ready;
  logic                valid;
  logic [N-1:0]        idx;
  logic                busy;
  logic                drop;

  modport master (
    input  enable, req, ready,
    output valid, idx, busy, drop
  );

  modport slave (
    output enable, req, ready,
    input  valid, idx, busy, drop
  );
endinterface

// File: rtl/event_encoder_nbit_prio_pick.sv
// Combinational wrap-around priority search: finds the first set bit of vec
// at or after start, scanning upward modulo 2**N.
module prio_pick #(
  parameter int N = 3
) (
  input  logic [(1<<N)-1:0] vec,
  input  logic [N-1:0]      start,
  output logic              found,
  output logic [N-1:0]      index
);
  localparam int W = 1 << N;

  logic [W-1:0] rot;
  logic [N-1:0] pos;

  // Rotate so that bit "start" lands at position 0; N-bit addition wraps.
  for (genvar gi = 0; gi < W; gi++) begin : g_rot
    assign rot[gi] = vec[N'(gi) + start];
  end

  always_comb begin
    pos = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (rot[i]) begin
        pos = N'(i);
      end
    end
  end

  assign found = |vec;
  assign index = pos + start;

endmodule

// File: rtl/event_encoder_nbit.sv
// Latches 2**N event strobes into a pending register and issues them as N-bit
// indices over valid/ready, in fixed-priority or round-robin order.
module event_encoder_nbit #(
  parameter int N  = 3,
  parameter bit RR = 1'b0
) (
  input  logic                clk,
  input  logic                reset_n,
  event_encoder_nbit_if.master bus
);
  import encoder_pkg::*;

  localparam int W     = 1 << N;
  localparam int IDX_W = clog2(W);

  logic [W-1:0]     pending_reg;
  logic             valid_reg;
  logic [N-1:0]     idx_reg;
  logic [N-1:0]     last_reg;
  logic             drop_reg;

  logic [W-1:0]     cap;
  logic [W-1:0]     cand;
  logic [W-1:0]     pick_mask;
  logic [N-1:0]     start;
  logic [IDX_W-1:0] pick_idx;
  logic             found;
  logic             load;

  assign cap       = bus.enable ? bus.req : '0;
  assign cand      = pending_reg | cap;
  assign start     = RR ? (last_reg + N'(1)) : '0;
  assign load      = ~valid_reg | bus.ready;
  assign pick_mask = W'(onehot(32'(pick_idx)));

  prio_pick #(.N(N)) u_pick (
    .vec   (cand),
    .start (start),
    .found (found),
    .index (pick_idx)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_reg <= '0;
      valid_reg   <= 1'b0;
      idx_reg     <= '0;
      last_reg    <= RR_LAST_RESET[N-1:0];
      drop_reg    <= 1'b0;
    end else begin
      // Merges are counted against pending bits only, not the held index.
      drop_reg <= |(cap & pending_reg);
      if (load) begin
        if (found) begin
          idx_reg     <= pick_idx;
          valid_reg   <= 1'b1;
          pending_reg <= cand & ~pick_mask;
          last_reg    <= pick_idx;
        end else begin
          valid_reg   <= 1'b0;
          pending_reg <= '0;
        end
      end else begin
        pending_reg <= cand;
      end
    end
  end

  assign bus.valid = valid_reg;
  assign bus.idx   = idx_reg;
  assign bus.drop  = drop_reg;
  assign bus.busy  = (|pending_reg) | valid_reg;

endmodule

// File: tb/tb_event_encoder_nbit.sv
// Scoreboard bench for event_encoder_nbit: one fixed-priority and one
// round-robin instance, expected indices queued by stimulus, popped by monitors.
module tb_event_encoder_nbit;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   q0[$];
  int   q1[$];

  always #5 clk = ~clk;

  event_encoder_nbit_if #(.N(3)) bus0 ();
  event_encoder_nbit_if #(.N(3)) bus1 ();

  event_encoder_nbit #(.N(3), .RR(1'b0)) dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus0)
  );

  event_encoder_nbit #(.N(3), .RR(1'b1)) dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end else begin
      $display("ok   %s value=%0d", name, actual);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    int e;
    if (reset_n && bus0.valid && bus0.ready) begin
      if (q0.size() == 0) begin
        total++;
        bad++;
        $display("FAIL fp_unexpected idx=%0d expected=none", bus0.idx);
      end else begin
        e = q0.pop_front();
        check("fp_idx", 32'(bus0.idx), e);
      end
    end
  end

  always @(negedge clk) begin
    int e;
    if (reset_n && bus1.valid && bus1.ready) begin
      if (q1.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rr_unexpected idx=%0d expected=none", bus1.idx);
      end else begin
        e = q1.pop_front();
        check("rr_idx", 32'(bus1.idx), e);
      end
    end
  end

  initial begin
    int rr_seq[17];
    rr_seq = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 3, 4, 5, 6, 7, 0};

    bus0.enable = 1'b1; bus0.req = 8'h00; bus0.ready = 1'b1;
    bus1.enable = 1'b1; bus1.req = 8'h00; bus1.ready = 1'b1;

    #1 reset_n = 1'b0;
    #3;
    check("rst_valid", 32'(bus0.valid), 0);
    check("rst_idx",   32'(bus0.idx),   0);
    check("rst_busy",  32'(bus0.busy),  0);
    check("rst_drop",  32'(bus0.drop),  0);
    cyc(2);
    reset_n = 1'b1;
    cyc(1);

    // single event
    bus0.req = 8'b0010_0000;
    q0.push_back(5);
    cyc(1);
    bus0.req = 8'h00;
    check("single_valid", 32'(bus0.valid), 1);
    check("single_idx",   32'(bus0.idx),   5);
    cyc(1);
    check("single_gone", 32'(bus0.valid), 0);
    check("single_busy", 32'(bus0.busy),  0);

    // burst serialized lowest first
    bus0.req = 8'hA5;
    q0.push_back(0); q0.push_back(2); q0.push_back(5); q0.push_back(7);
    cyc(1);
    bus0.req = 8'h00;
    cyc(4);
    check("burst_done_valid", 32'(bus0.valid), 0);
    check("burst_done_busy",  32'(bus0.busy),  0);

    // stall and merge
    bus0.ready = 1'b0;
    bus0.req = 8'h06;
    cyc(1);
    bus0.req = 8'h00;
    check("stall1_valid", 32'(bus0.valid), 1);
    check("stall1_idx",   32'(bus0.idx),   1);
    check("stall1_drop",  32'(bus0.drop),  0);
    cyc(1);
    check("stall2_idx",  32'(bus0.idx),  1);
    check("stall2_drop", 32'(bus0.drop), 0);
    bus0.req = 8'h04;
    cyc(1);
    bus0.req = 8'h00;
    check("stall3_idx",  32'(bus0.idx),  1);
    check("stall3_drop", 32'(bus0.drop), 1);
    cyc(1);
    check("stall4_idx",  32'(bus0.idx),  1);
    check("stall4_drop", 32'(bus0.drop), 0);
    check("stall4_busy", 32'(bus0.busy), 1);
    q0.push_back(1); q0.push_back(2);
    bus0.ready = 1'b1;
    cyc(1);
    check("merge_next_idx", 32'(bus0.idx), 2);
    cyc(1);
    check("merge_done_valid", 32'(bus0.valid), 0);
    check("merge_done_busy",  32'(bus0.busy),  0);

    // enable gating
    bus0.enable = 1'b0;
    bus0.req = 8'hFF;
    cyc(3);
    check("gate_valid", 32'(bus0.valid), 0);
    check("gate_busy",  32'(bus0.busy),  0);
    check("gate_drop",  32'(bus0.drop),  0);
    for (int i = 0; i < 8; i++) q0.push_back(i);
    bus0.enable = 1'b1;
    cyc(1);
    bus0.enable = 1'b0;
    cyc(8);
    check("gate_done_valid", 32'(bus0.valid), 0);
    bus0.req = 8'h00;
    bus0.enable = 1'b1;

    // round-robin: 10 edges of full requests, then drain the residue
    for (int i = 0; i < 17; i++) q1.push_back(rr_seq[i]);
    bus1.req = 8'hFF;
    cyc(10);
    bus1.req = 8'h00;
    cyc(8);
    check("rr_done_valid", 32'(bus1.valid), 0);
    check("rr_done_busy",  32'(bus1.busy),  0);

    // asynchronous reset mid-transfer: valid=1, pending=0A, drop=1
    bus0.ready = 1'b0;
    bus0.req = 8'h0B;
    cyc(1);
    bus0.req = 8'h08;
    cyc(1);
    bus0.req = 8'h00;
    check("pre_rst_valid", 32'(bus0.valid), 1);
    check("pre_rst_drop",  32'(bus0.drop),  1);
    check("pre_rst_busy",  32'(bus0.busy),  1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus0.valid), 0);
    check("mid_rst_idx",   32'(bus0.idx),   0);
    check("mid_rst_busy",  32'(bus0.busy),  0);
    check("mid_rst_drop",  32'(bus0.drop),  0);
    cyc(1);
    reset_n = 1'b1;
    bus0.ready = 1'b1;
    cyc(2);
    check("post_rst_busy",  32'(bus0.busy),  0);
    check("post_rst_valid", 32'(bus0.valid), 0);

    check("fp_queue_left", 32'(q0.size()), 0);
    check("rr_queue_left", 32'(q1.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/event_encoder_nbit.md
# event_encoder_nbit

Sequential N-bit event encoder that converts 2**N request lines into a stream of N-bit binary indices, one per accepted transfer. Requests are latched into a pending register, so no event is lost while the consumer stalls. Indices are issued over a valid/ready handshake in fixed-priority or round-robin order. It is the encoding counterpart of `decoder_nbit` and feeds index-based consumers such as interrupt controllers and mux selects.

## Interface
- `N`, default 3: index width; the request vector is 2**N bits wide.
- `RR`, default 0: 0 = fixed priority (lowest index first); 1 = round-robin (search starts after the last issued index).
- `clk`, input, 1: rising-edge clock.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `enable`, input, 1: when 1, `req` is captured each cycle; when 0, `req` is ignored and the output keeps draining.
- `req`, input, 2**N: event strobes; any set bit is one event for that index.
- `ready`, input, 1: consumer accepts `idx` this cycle when `valid` is 1.
- `valid`, output, 1: `idx` holds an issued event.
- `idx`, output, N: binary index of the held event.
- `busy`, output, 1: OR of all pending bits OR `valid`.
- `drop`, output, 1: one-cycle pulse; an event merged into an already-pending bit.

## Operation
- State: `pending[2**N-1:0]`, output register (`valid`, `idx`), RR pointer `last[N-1:0]`, `drop` register.
- Reset values: `pending`=0, `valid`=0, `idx`=0, `drop`=0, `last`=2**N-1 (so the first RR search starts at 0). `busy` is combinational and therefore 0.
- `cap` = `enable` ? `req` : 0.
- `cand` = `pending` | `cap`.
- The output register loads when `valid`=0 or (`valid` & `ready`) (load condition).
- On load with `cand`≠0:
  - Pick bit `p`.
    - RR=0: lowest set bit of `cand`.
    - RR=1: first set bit scanning `last`+1, `last`+2, … modulo 2**N.
  - Set `idx`=`p`, `valid`=1, `pending` = `cand` & ~(1<<`p`), `last`=`p`.
- On load with `cand`=0: `valid`=0, `pending`=0, `idx` holds its value.
- No load (`valid`=1, `ready`=0): `pending` = `cand`; `idx`, `valid` and `last` hold.
- An event on the index currently held in `idx` is a new event: it goes into `pending` and is issued again later.
- `drop` is registered as |(`cap` & `pending`), using the pre-edge `pending`. This counts merges with pending bits only, not with the bit held in `idx`.
- `idx` and `valid` are stable while `valid`=1 and `ready`=0.
- Reset mid-transfer clears everything immediately. Events held in `pending` or the output are lost.

## Timing
- Latency: `req` sampled at edge k with the output free gives `valid`=1 and `idx` from edge k onward. The event is visible in the cycle after it was presented.
- Throughput: one index per cycle while `ready`=1 and `cand`≠0.
- There is no combinational path from `req` or `ready` to `valid`/`idx`. `busy` is combinational from registers only.
- Several simultaneous requests are serialized in priority order, one per accepted cycle.
- `ready` while `valid`=0 has no effect.

## Structure
- Package `encoder_pkg` provides:
  - the `clog2`-style width helper;
  - the `onehot(idx)` function;
  - the RR pointer reset constant.
- Sub-module `prio_pick`, parameterized by N and purely combinational:
  - inputs: vector and start index;
  - outputs: found flag and N-bit index;
  - the wrap-around scan is done as a rotate, then priority search, then un-rotate.
- The top level holds all registers and the handshake logic and instantiates `prio_pick` once. RR=0 ties the start index to 0.

## Test plan
All scenarios use N=3.
- **Reset:** assert `reset_n`=0 mid-stream with `valid`=1 and `pending`=8'h0A. All outputs go to 0 asynchronously; after release, `busy`=0.
- **Single event (RR=0):** `req`=8'b0010_0000 for one cycle, `ready`=1. `valid`=1 and `idx`=5 for exactly one cycle starting the next cycle.
- **Burst (RR=0):** `req`=8'hA5 for one cycle, `ready`=1. `idx` sequence is 0, 2, 5, 7 on consecutive cycles, then `valid`=0.
- **Stall and merge:** `req`=8'h06, `ready`=0 for 4 cycles, with `req`=8'h04 again in cycle 3.
  - `idx`=1 is held stable and `drop` pulses once.
  - After `ready`=1: `idx` sequence is 1, 2, with no duplicate 2.
- **Round-robin (RR=1):** `req`=8'hFF held with `ready`=1. `idx` sequence is 0, 1, …, 7, 0, 1, and index 7 wraps to 0.
- **Enable gating:** `enable`=0 with `req`=8'hFF gives `valid`=0 and `busy`=0. Then `enable`=1 for one cycle gives `valid` for 8 transfers.
